// File: rtl/rv32i_pkg.sv
// RV32I opcode, funct3 and ALU-op encodings shared by the decode datapath.
package rv32i_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [2:0] F3_ADD_SUB = 3'd0;
    localparam logic [2:0] F3_SLL     = 3'd1;
    localparam logic [2:0] F3_SLT     = 3'd2;
    localparam logic [2:0] F3_SLTU    = 3'd3;
    localparam logic [2:0] F3_XOR     = 3'd4;
    localparam logic [2:0] F3_SR      = 3'd5;
    localparam logic [2:0] F3_OR      = 3'd6;
    localparam logic [2:0] F3_AND     = 3'd7;

    localparam logic [31:0] NOP_INST = 32'h00000013;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_fmt_e;

    // alt selects SUB/SRA (instruction bit 30) where funct3 has two meanings
    function automatic alu_op_e alu_from_funct3(input logic [2:0] f3, input logic alt);
        case (f3)
            F3_ADD_SUB: return alt ? ALU_SUB : ALU_ADD;
            F3_SLL:     return ALU_SLL;
            F3_SLT:     return ALU_SLT;
            F3_SLTU:    return ALU_SLTU;
            F3_XOR:     return ALU_XOR;
            F3_SR:      return alt ? ALU_SRA : ALU_SRL;
            F3_OR:      return ALU_OR;
            default:    return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate generator; all formats sign-extend from inst[31].
module imm_gen
    import rv32i_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst_i,
    input  imm_fmt_e        fmt_i,
    output logic [XLEN-1:0] imm_o
);

    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (fmt_i)
            IMM_I: imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
            IMM_S: imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            IMM_B: imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                            inst_i[11:8], 1'b0};
            IMM_U: imm32 = {inst_i[31:12], 12'b0};
            IMM_J: imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                            inst_i[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// RV32I ID stage: control decode, operand capture, load-use stall into the ID/EX register.
// Optional illegal-instruction detection is enabled by defining DECODE_ILLEGAL_EN.
module decode_stage
    import rv32i_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              resetb,
    input  logic              if_valid,
    input  logic [XLEN-1:0]   if_pc,
    input  logic [31:0]       if_inst,
    output logic              id_ready,
    output logic [REG_AW-1:0] a_rs1,
    output logic [REG_AW-1:0] a_rs2,
    input  logic [XLEN-1:0]   d_rs1,
    input  logic [XLEN-1:0]   d_rs2,
    input  logic              ex_flush,
    input  logic              ex_stall,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_rs1_val,
    output logic [XLEN-1:0]   ex_rs2_val,
    output logic [XLEN-1:0]   ex_imm,
    output logic [REG_AW-1:0] ex_rs1,
    output logic [REG_AW-1:0] ex_rs2,
    output logic [REG_AW-1:0] ex_rd,
    output logic [3:0]        ex_alu_op,
    output logic [2:0]        ex_funct3,
    output logic              ex_alu_src_imm,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_reg_write,
    output logic              ex_branch,
    output logic              ex_jal,
    output logic              ex_jalr,
    output logic              ex_lui,
    output logic              ex_auipc,
    output logic              ex_illegal
);

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   rs1_val;
        logic [XLEN-1:0]   rs2_val;
        logic [XLEN-1:0]   imm;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        alu_op_e           alu_op;
        logic [2:0]        funct3;
        logic              alu_src_imm;
        logic              mem_read;
        logic              mem_write;
        logic              reg_write;
        logic              branch;
        logic              jal;
        logic              jalr;
        logic              lui;
        logic              auipc;
        logic              illegal;
    } idex_t;

    idex_t           ex_q, ex_d, dec, dec_full;
    imm_fmt_e        imm_fmt;
    logic [XLEN-1:0] imm_val;
    logic            use_rs1, use_rs2, hazard;
    logic [6:0]      opcode;
    logic [2:0]      funct3;

    assign opcode = if_inst[6:0];
    assign funct3 = if_inst[14:12];
    assign a_rs1  = REG_AW'(if_inst[19:15]);
    assign a_rs2  = REG_AW'(if_inst[24:20]);

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .inst_i (if_inst),
        .fmt_i  (imm_fmt),
        .imm_o  (imm_val)
    );

    always_comb begin
        dec         = '0;
        use_rs1     = 1'b0;
        use_rs2     = 1'b0;
        imm_fmt     = IMM_NONE;
        dec.valid   = 1'b1;
        dec.pc      = if_pc;
        dec.funct3  = funct3;
        dec.rd      = REG_AW'(if_inst[11:7]);
        dec.alu_op  = ALU_ADD;
        case (opcode)
            OPC_LUI: begin
                imm_fmt = IMM_U;
                dec.reg_write = 1'b1; dec.alu_src_imm = 1'b1; dec.lui = 1'b1;
                dec.alu_op = ALU_PASS_B;
            end
            OPC_AUIPC: begin
                imm_fmt = IMM_U;
                dec.reg_write = 1'b1; dec.alu_src_imm = 1'b1; dec.auipc = 1'b1;
            end
            OPC_JAL: begin
                imm_fmt = IMM_J;
                dec.reg_write = 1'b1; dec.jal = 1'b1;
            end
            OPC_JALR: begin
                imm_fmt = IMM_I; use_rs1 = 1'b1;
                dec.reg_write = 1'b1; dec.jalr = 1'b1; dec.alu_src_imm = 1'b1;
            end
            OPC_BRANCH: begin
                imm_fmt = IMM_B; use_rs1 = 1'b1; use_rs2 = 1'b1;
                dec.branch = 1'b1; dec.alu_op = ALU_SUB;
            end
            OPC_LOAD: begin
                imm_fmt = IMM_I; use_rs1 = 1'b1;
                dec.mem_read = 1'b1; dec.reg_write = 1'b1; dec.alu_src_imm = 1'b1;
            end
            OPC_STORE: begin
                imm_fmt = IMM_S; use_rs1 = 1'b1; use_rs2 = 1'b1;
                dec.mem_write = 1'b1; dec.alu_src_imm = 1'b1;
            end
            OPC_OP_IMM: begin
                imm_fmt = IMM_I; use_rs1 = 1'b1;
                dec.reg_write = 1'b1; dec.alu_src_imm = 1'b1;
                dec.alu_op = alu_from_funct3(funct3, (funct3 == F3_SR) & if_inst[30]);
            end
            OPC_OP: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_op = alu_from_funct3(funct3, if_inst[30]);
            end
            OPC_MISC_MEM, OPC_SYSTEM: imm_fmt = IMM_I;
            default: ;
        endcase
        // unused source fields are zeroed so EX bypass never matches on them
        dec.rs1     = use_rs1 ? a_rs1 : '0;
        dec.rs2     = use_rs2 ? a_rs2 : '0;
        dec.rs1_val = use_rs1 ? d_rs1 : '0;
        dec.rs2_val = use_rs2 ? d_rs2 : '0;
    end

`ifdef DECODE_ILLEGAL_EN
    logic       illegal;
    logic [6:0] funct7;

    assign funct7 = if_inst[31:25];

    always_comb begin
        illegal = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
            OPC_STORE, OPC_MISC_MEM, OPC_SYSTEM: illegal = 1'b0;
            OPC_OP:
                illegal = !((funct7 == 7'h00) ||
                            ((funct7 == 7'h20) && ((funct3 == F3_ADD_SUB) || (funct3 == F3_SR))));
            OPC_OP_IMM:
                if (funct3 == F3_SLL)     illegal = (funct7 != 7'h00);
                else if (funct3 == F3_SR) illegal = (funct7 != 7'h00) && (funct7 != 7'h20);
            default: illegal = 1'b1;
        endcase
    end
`endif

    always_comb begin
        dec_full     = dec;
        dec_full.imm = imm_val;
`ifdef DECODE_ILLEGAL_EN
        // illegal entries stay valid so EX can trap, but lose every side effect
        if (illegal) begin
            dec_full.reg_write = 1'b0;
            dec_full.mem_read  = 1'b0;
            dec_full.mem_write = 1'b0;
            dec_full.branch    = 1'b0;
            dec_full.jal       = 1'b0;
            dec_full.jalr      = 1'b0;
        end
        dec_full.illegal = illegal;
`endif
    end

    assign hazard = ex_q.valid & ex_q.mem_read & (ex_q.rd != '0) & if_valid &
                    ((use_rs1 & (a_rs1 == ex_q.rd)) | (use_rs2 & (a_rs2 == ex_q.rd)));

    assign id_ready = ~resetb | ex_flush | (~ex_stall & ~hazard);

    always_comb begin
        ex_d = ex_q;
        if (ex_flush)      ex_d = '0;
        else if (ex_stall) ex_d = ex_q;
        else if (hazard)   ex_d = '0;
        else if (if_valid) ex_d = dec_full;
        else               ex_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!resetb) ex_q <= '0;
        else         ex_q <= ex_d;
    end

    assign ex_valid       = ex_q.valid;
    assign ex_pc          = ex_q.pc;
    assign ex_rs1_val     = ex_q.rs1_val;
    assign ex_rs2_val     = ex_q.rs2_val;
    assign ex_imm         = ex_q.imm;
    assign ex_rs1         = ex_q.rs1;
    assign ex_rs2         = ex_q.rs2;
    assign ex_rd          = ex_q.rd;
    assign ex_alu_op      = ex_q.alu_op;
    assign ex_funct3      = ex_q.funct3;
    assign ex_alu_src_imm = ex_q.alu_src_imm;
    assign ex_mem_read    = ex_q.mem_read;
    assign ex_mem_write   = ex_q.mem_write;
    assign ex_reg_write   = ex_q.reg_write;
    assign ex_branch      = ex_q.branch;
    assign ex_jal         = ex_q.jal;
    assign ex_jalr        = ex_q.jalr;
    assign ex_lui         = ex_q.lui;
    assign ex_auipc       = ex_q.auipc;
    assign ex_illegal     = ex_q.illegal;

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- ID stage of the 5-stage RV32I iCE40 pipeline; sits between fetch and execute.
- Drives the `regfile` read addresses combinationally from the fetched instruction and captures `d_rs1`/`d_rs2` into the ID/EX pipeline register.
- Decodes control signals and the immediate, and detects load-use hazards, stalling fetch and inserting a bubble.
- Honours flush from EX (taken branch/jump) and stall from later stages.

Parameters:
- XLEN, 32, datapath width
- REG_AW, 5, register address width

Ports:
- clk  in  1  clock
- resetb  in  1  synchronous active-low reset
- if_valid  in  1  fetch presents a valid instruction
- if_pc  in  XLEN  PC of fetched instruction
- if_inst  in  32  fetched instruction word
- id_ready  out  1  ID accepts if_inst this cycle (fetch holds when 0)
- a_rs1  out  REG_AW  regfile rs1 address = if_inst[19:15]
- a_rs2  out  REG_AW  regfile rs2 address = if_inst[24:20]
- d_rs1  in  XLEN  regfile rs1 data (combinational, same-cycle write bypass, x0 reads 0)
- d_rs2  in  XLEN  regfile rs2 data
- ex_flush  in  1  kill instruction in ID and squash the ID/EX entry
- ex_stall  in  1  downstream cannot accept; hold ID/EX
- ex_valid  out  1  ID/EX entry valid
- ex_pc, ex_rs1_val, ex_rs2_val, ex_imm  out  XLEN  registered operands
- ex_rs1, ex_rs2, ex_rd  out  REG_AW  registered register addresses (used for EX bypass)
- ex_alu_op  out  4  ALU operation (package encoding)
- ex_funct3  out  3  funct3 passthrough (branch condition / load-store size)
- ex_alu_src_imm, ex_mem_read, ex_mem_write, ex_reg_write, ex_branch, ex_jal, ex_jalr, ex_lui, ex_auipc  out  1 each  control
- ex_illegal  out  1  illegal instruction flag (see Optional Feature)

Behaviour:
- Reset:
  - Synchronous reset, sampled at posedge clk with resetb=0.
  - All ex_* outputs clear to 0.
  - id_ready=1 during reset.
  - Reset mid-operation discards the ID/EX entry with no residual stall.
- Latency:
  - Instruction accepted at cycle N appears on ex_* at cycle N+1.
  - a_rs1/a_rs2 are purely combinational from if_inst, so regfile data is valid in the same cycle.
- Immediate:
  - I, S, B, U and J formats, all sign-extended from inst[31].
  - B and J immediates have bit0=0.
  - R-type immediate = 0.
- Register use:
  - rs1 used by OP, OP-IMM, LOAD, STORE, BRANCH, JALR.
  - rs2 used by OP, STORE, BRANCH.
  - LUI, AUIPC and JAL use neither.
- Load-use hazard: hazard = ex_valid & ex_mem_read & ex_rd!=0 & if_valid & (rs1 used & rs1==ex_rd | rs2 used & rs2==ex_rd).
  - On hazard: id_ready=0 and ID/EX is loaded with a bubble (ex_valid=0, all controls 0).
  - The stall lasts exactly 1 cycle, because the bubble clears the hazard.
- Stall: ex_stall=1 → ID/EX holds all values, id_ready=0.
- Priority, per cycle (highest first):
  1. reset
  2. ex_flush: ID/EX ← bubble, id_ready=1, incoming instruction dropped
  3. ex_stall: hold
  4. hazard: bubble
  5. if_valid: load decoded instruction
  6. otherwise: bubble
- id_ready = ~ex_stall & ~hazard | ex_flush.
- Bubble contents:
  - A bubble never asserts ex_reg_write, ex_mem_read or ex_mem_write.
  - On a bubble, data fields may hold don't-care values; the implementation zeroes them.
- rd==0: ex_reg_write may be 1; x0 writes are discarded by the regfile.

Optional Feature:
- Macro DECODE_ILLEGAL_EN.
- When defined:
  - Opcodes outside the RV32I base set (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, MISC-MEM, SYSTEM) set ex_illegal=1.
  - Invalid funct3/funct7 combinations for OP/OP-IMM shifts set ex_illegal=1.
  - When ex_illegal=1: ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jal and ex_jalr are forced to 0; ex_valid stays 1.
- When undefined: ex_illegal tied to 0; unknown opcodes decode as NOP (all controls 0).

Decomposition:
- Package `rv32i_pkg`:
  - opcode constants.
  - funct3 constants.
  - ALU op encodings (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B).
  - NOP word 32'h00000013.
- Sub-module `imm_gen`: combinational immediate generator, shared with any later pre-decode.
- Hazard detection and control decode stay in `decode_stage`.

Test Plan:
- Reset: resetb=0 for 2 cycles with if_valid=1 → ex_valid=0, all ex_* 0, id_ready=1.
- ADDI x1,x0,5 (0x00500093) → next cycle: ex_valid=1, ex_rd=1, ex_imm=5, ex_alu_src_imm=1, ex_reg_write=1, ex_rs1_val=0.
- LW x2,0(x1) (0x0000A103) then ADD x3,x2,x1 (0x001101B3) → one cycle with id_ready=0 and bubble (ex_valid=0), then ADD issues with ex_rd=3, ex_rs1=2, ex_rs2=1.
- Load to x0 followed by a reader of x0 → no stall; id_ready stays 1.
- BEQ x0,x0,-4 (0xFE000EE3) → ex_imm=0xFFFFFFFC, ex_branch=1, ex_reg_write=0.
- ex_flush and ex_stall asserted together during a load-use hazard → next cycle ex_valid=0, id_ready=1 in the flush cycle; illegal opcode 0x0000007F with DECODE_ILLEGAL_EN → ex_illegal=1, ex_reg_write=0.
